// File: rtl/oscilloscope_pkg.sv
// Shared types and constants for the ADC sample demux path.
package oscilloscope_pkg;

  localparam int SAMPLE_BITS_DEFAULT = 12;

  // Channel tags carried on adcChannel
  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;

  typedef enum logic [1:0] {
    UNSYNCED   = 2'd0,
    EXPECT_CH1 = 2'd1,
    EXPECT_CH2 = 2'd2
  } demux_state_t;

endpackage

// File: rtl/channel_sample_demux_if.sv
// ADC sample stream in, per-channel data/slope/sequencing status out.
interface channel_sample_demux_if #(
  parameter int SAMPLE_BITS = 12
);
  logic [SAMPLE_BITS-1:0] adcData;
  logic                   adcValid;
  logic                   adcChannel;
  logic [SAMPLE_BITS-1:0] channel1;
  logic [SAMPLE_BITS-1:0] channel2;
  logic                   channel1Valid;
  logic                   channel2Valid;
  logic                   positiveSlopeChannel1;
  logic                   positiveSlopeChannel2;
  logic                   synced;
  logic                   sequenceError;

  // Sample producer side
  modport master (
    output adcData, adcValid, adcChannel,
    input  channel1, channel2, channel1Valid, channel2Valid,
           positiveSlopeChannel1, positiveSlopeChannel2, synced, sequenceError
  );

  // Demux side
  modport slave (
    input  adcData, adcValid, adcChannel,
    output channel1, channel2, channel1Valid, channel2Valid,
           positiveSlopeChannel1, positiveSlopeChannel2, synced, sequenceError
  );
endinterface

// File: rtl/channel_sample_demux_slope_tracker.sv
// Hysteresis slope flag for one channel. The first sample after reset
// only primes the previous-sample register.
module slope_tracker #(
  parameter int SAMPLE_BITS = 12
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [SAMPLE_BITS-1:0] sample,
  input  logic                   load,
  input  logic [SAMPLE_BITS-1:0] hysteresis,
  output logic                   slope
);
  logic [SAMPLE_BITS-1:0] prev;
  logic                   primed;
  logic [SAMPLE_BITS:0]   sampleWide, prevWide, hystWide;
  logic                   rising, falling;

  // One extra bit so prev+hysteresis and sample+hysteresis never wrap
  assign sampleWide = {1'b0, sample};
  assign prevWide   = {1'b0, prev};
  assign hystWide   = {1'b0, hysteresis};
  assign rising     = sampleWide > (prevWide + hystWide);
  assign falling    = (sampleWide + hystWide) < prevWide;

  // Track previous sample and move the flag only on a clear excursion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev   <= '0;
      primed <= 1'b0;
      slope  <= 1'b0;
    end else if (load) begin
      prev   <= sample;
      primed <= 1'b1;
      if (primed) begin
        if (rising)       slope <= 1'b1;
        else if (falling) slope <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/channel_sample_demux.sv
// Splits the interleaved ch1/ch2 ADC stream into registered per-channel
// outputs, tracks strict alternation and flags sequencing faults.
module channel_sample_demux
  import oscilloscope_pkg::*;
#(
  parameter int SAMPLE_BITS      = SAMPLE_BITS_DEFAULT,
  parameter int SLOPE_HYSTERESIS = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  channel_sample_demux_if.slave adc
);
  localparam logic [SAMPLE_BITS-1:0] HYST = SAMPLE_BITS'(SLOPE_HYSTERESIS);

  demux_state_t           state, stateNext;
  logic                   accept1, accept2, errNext;
  logic [SAMPLE_BITS-1:0] channel1Q, channel2Q;
  logic                   valid1Q, valid2Q, errQ;

  // Next-state and accept decisions for the alternation tracker
  always_comb begin
    stateNext = state;
    accept1   = 1'b0;
    accept2   = 1'b0;
    errNext   = 1'b0;
    if (adc.adcValid) begin
      unique case (state)
        UNSYNCED: begin
          // A stray ch2 while unlocked is dropped silently
          if (adc.adcChannel == CH1) begin
            accept1   = 1'b1;
            stateNext = EXPECT_CH2;
          end
        end
        EXPECT_CH2: begin
          if (adc.adcChannel == CH2) begin
            accept2   = 1'b1;
            stateNext = EXPECT_CH1;
          end else begin
            // Repeated ch1: keep the newer sample and stay locked on it
            errNext = 1'b1;
            accept1 = 1'b1;
          end
        end
        EXPECT_CH1: begin
          if (adc.adcChannel == CH1) begin
            accept1   = 1'b1;
            stateNext = EXPECT_CH2;
          end else begin
            errNext   = 1'b1;
            stateNext = UNSYNCED;
          end
        end
        default: stateNext = UNSYNCED;
      endcase
    end
  end

  // State, data and one-cycle pulse registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= UNSYNCED;
      channel1Q <= '0;
      channel2Q <= '0;
      valid1Q   <= 1'b0;
      valid2Q   <= 1'b0;
      errQ      <= 1'b0;
    end else begin
      state   <= stateNext;
      valid1Q <= accept1;
      valid2Q <= accept2;
      errQ    <= errNext;
      if (accept1) channel1Q <= adc.adcData;
      if (accept2) channel2Q <= adc.adcData;
    end
  end

  slope_tracker #(.SAMPLE_BITS(SAMPLE_BITS)) slope1 (
    .clock(clock), .reset_n(reset_n), .sample(adc.adcData), .load(accept1),
    .hysteresis(HYST), .slope(adc.positiveSlopeChannel1)
  );

  slope_tracker #(.SAMPLE_BITS(SAMPLE_BITS)) slope2 (
    .clock(clock), .reset_n(reset_n), .sample(adc.adcData), .load(accept2),
    .hysteresis(HYST), .slope(adc.positiveSlopeChannel2)
  );

  assign adc.channel1      = channel1Q;
  assign adc.channel2      = channel2Q;
  assign adc.channel1Valid = valid1Q;
  assign adc.channel2Valid = valid2Q;
  assign adc.sequenceError = errQ;
  assign adc.synced        = (state != UNSYNCED);
endmodule

// File: tb/tb_channel_sample_demux.sv
// Directed vector table plus randomized traffic against a reference model.
module tb_channel_sample_demux;
  localparam int SB   = 12;
  localparam int HYST = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  channel_sample_demux_if #(.SAMPLE_BITS(SB)) bus ();

  channel_sample_demux #(.SAMPLE_BITS(SB), .SLOPE_HYSTERESIS(HYST)) dut (
    .clock(clock), .reset_n(reset_n), .adc(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit rst;
    bit v;
    bit c;
    int d;
    int e1;
    int e2;
    bit ev1, ev2, es1, es2, esy, eerr;
  } vec_t;
  vec_t tbl[$];

  // Reference model: what each channel last saw and what tag comes next
  bit mLocked, mWant, mErr;
  int mData[2], mPrev[2];
  bit mPrimed[2], mSlope[2], mVld[2];

  function automatic logic [29:0] pack(int e1, int e2, bit v1, bit v2,
                                       bit s1, bit s2, bit sy, bit er);
    return {12'(e1), 12'(e2), v1, v2, s1, s2, sy, er};
  endfunction

  function automatic logic [29:0] dutOut();
    return {bus.channel1, bus.channel2, bus.channel1Valid, bus.channel2Valid,
            bus.positiveSlopeChannel1, bus.positiveSlopeChannel2,
            bus.synced, bus.sequenceError};
  endfunction

  task automatic check(string name, logic [29:0] act, logic [29:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ch1=%0d ch2=%0d v1v2s1s2 sy err=%b, want ch1=%0d ch2=%0d v1v2s1s2 sy err=%b",
               name, act[29:18], act[17:6], act[5:0], exp[29:18], exp[17:6], exp[5:0]);
    end
  endtask

  function automatic void modelReset();
    mLocked = 0; mWant = 0; mErr = 0;
    for (int k = 0; k < 2; k++) begin
      mData[k] = 0; mPrev[k] = 0; mPrimed[k] = 0; mSlope[k] = 0; mVld[k] = 0;
    end
  endfunction

  function automatic void accept(int k, int d);
    mData[k] = d;
    mVld[k]  = 1;
    if (!mPrimed[k])              mPrimed[k] = 1;
    else if (d > mPrev[k] + HYST) mSlope[k]  = 1;
    else if (d + HYST < mPrev[k]) mSlope[k]  = 0;
    mPrev[k] = d;
  endfunction

  function automatic void modelStep(bit v, bit c, int d);
    mVld[0] = 0; mVld[1] = 0; mErr = 0;
    if (v) begin
      if (!mLocked) begin
        if (c == 0) begin accept(0, d); mLocked = 1; mWant = 1; end
      end else if (c == mWant) begin
        accept(int'(c), d);
        mWant = ~c;
      end else begin
        mErr = 1;
        if (c == 0) accept(0, d);
        else        mLocked = 0;
      end
    end
  endfunction

  function automatic logic [29:0] modelOut();
    return pack(mData[0], mData[1], mVld[0], mVld[1], mSlope[0], mSlope[1], mLocked, mErr);
  endfunction

  // Drive at the falling edge, let one rising edge pass, sample at the next fall
  task automatic drive(bit v, bit c, int d);
    bus.adcValid   = v;
    bus.adcChannel = c;
    bus.adcData    = 12'(d);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic mstep(string name, bit v, bit c, int d);
    drive(v, c, d);
    modelStep(v, c, d);
    check(name, dutOut(), modelOut());
  endtask

  task automatic add(bit rst, bit v, bit c, int d, int e1, int e2,
                     bit ev1, bit ev2, bit es1, bit es2, bit esy, bit eerr);
    vec_t x;
    x.rst = rst; x.v = v; x.c = c; x.d = d; x.e1 = e1; x.e2 = e2;
    x.ev1 = ev1; x.ev2 = ev2; x.es1 = es1; x.es2 = es2; x.esy = esy; x.eerr = eerr;
    tbl.push_back(x);
  endtask

  initial begin
    bus.adcValid = 0; bus.adcChannel = 0; bus.adcData = '0;
    reset_n = 0;
    repeat (2) @(negedge clock);
    check("reset", dutOut(), '0);
    reset_n = 1;

    //  rst v c  d     ch1   ch2  v1 v2 s1 s2 sy err
    // Basic alternation
    add(0, 1, 0, 100,  100,    0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 200,  100,  200, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 300,  300,  200, 1, 0, 1, 0, 1, 0);
    add(0, 1, 1, 400,  300,  400, 0, 1, 1, 1, 1, 0);
    add(0, 0, 0, 999,  300,  400, 0, 0, 1, 1, 1, 0);
    // Hysteresis on ch1, ch2 flat; 1010 is 10 below 1020 so the flag falls there
    add(1, 0, 0, 0,      0,    0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1000, 1000,   0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 500,  1000, 500, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 1005, 1005, 500, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 500,  1005, 500, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 1020, 1020, 500, 1, 0, 1, 0, 1, 0);
    add(0, 1, 1, 500,  1020, 500, 0, 1, 1, 0, 1, 0);
    add(0, 1, 0, 1010, 1010, 500, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 500,  1010, 500, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 990,   990, 500, 1, 0, 0, 0, 1, 0);
    // Unexpected ch2 in EXPECT_CH1 drops lock; stray ch2 ignored until ch1
    add(1, 0, 0, 0,      0,    0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 11,    11,    0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 22,    11,   22, 0, 1, 0, 0, 1, 0);
    add(0, 1, 1, 33,    11,   22, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0,     11,   22, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 44,    11,   22, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 55,    55,   22, 1, 0, 1, 0, 1, 0);
    // Repeated ch1 resyncs and stays expecting ch2
    add(1, 0, 0, 0,      0,    0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 10,    10,    0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 50,    50,    0, 1, 0, 1, 0, 1, 1);
    add(0, 1, 1, 60,    50,   60, 0, 1, 1, 0, 1, 0);
    // Full-scale boundaries on ch1
    add(1, 0, 0, 0,      0,    0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4000, 4000,   0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0,    4000,   0, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 4095, 4095,   0, 1, 0, 1, 0, 1, 0);
    add(0, 1, 1, 0,    4095,   0, 0, 1, 1, 0, 1, 0);
    add(0, 1, 0, 4095, 4095,   0, 1, 0, 1, 0, 1, 0);
    add(0, 1, 1, 0,    4095,   0, 0, 1, 1, 0, 1, 0);
    add(0, 1, 0, 4086, 4086,   0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0,    4086,   0, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0,       0,   0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0,       0,   0, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 8,       8,   0, 1, 0, 0, 0, 1, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        reset_n = 0;
        bus.adcValid = 0;
        #2;
        check($sformatf("vec%0d_reset", i), dutOut(), '0);
        @(negedge clock);
        reset_n = 1;
      end else begin
        drive(tbl[i].v, tbl[i].c, tbl[i].d);
        check($sformatf("vec%0d", i), dutOut(),
              pack(tbl[i].e1, tbl[i].e2, tbl[i].ev1, tbl[i].ev2,
                   tbl[i].es1, tbl[i].es2, tbl[i].esy, tbl[i].eerr));
      end
    end

    // Mid-stream reset with both slopes high, then priming-only samples
    reset_n = 0; #2; @(negedge clock); reset_n = 1;
    modelReset();
    mstep("mid_a", 1, 0, 100);
    mstep("mid_b", 1, 1, 100);
    mstep("mid_c", 1, 0, 200);
    mstep("mid_d", 1, 1, 200);
    checks++;
    if (!(bus.positiveSlopeChannel1 && bus.positiveSlopeChannel2)) begin
      errors++;
      $display("FAIL mid_slopes_high: got %b%b want 11",
               bus.positiveSlopeChannel1, bus.positiveSlopeChannel2);
    end
    bus.adcValid = 1; bus.adcChannel = 0; bus.adcData = 12'd3000;
    #2 reset_n = 0;
    #1;
    check("mid_async_reset", dutOut(), '0);
    bus.adcValid = 0;
    @(negedge clock);
    reset_n = 1;
    modelReset();
    mstep("mid_prime1", 1, 0, 2000);
    mstep("mid_prime2", 1, 1, 2000);
    mstep("mid_rise1",  1, 0, 2100);

    // Randomized traffic, mostly well-ordered, with faults and rail values
    modelReset();
    reset_n = 0; #2; @(negedge clock); reset_n = 1;
    for (int i = 0; i < 400; i++) begin
      bit v, c;
      int d, r;
      if (i == 200) begin
        reset_n = 0; bus.adcValid = 0; #2;
        check("rand_reset", dutOut(), '0);
        @(negedge clock);
        reset_n = 1;
        modelReset();
      end
      v = ($urandom_range(0, 9) < 7);
      if (mLocked && $urandom_range(0, 99) < 85) c = mWant;
      else                                       c = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 19));
      d = mData[c] + int'($urandom_range(0, 40)) - 20;
      if (r == 0) d = 0;
      if (r == 1) d = 4095;
      if (d < 0) d = 0;
      if (d > 4095) d = 4095;
      mstep($sformatf("rand%0d", i), v, c, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
